// File: rtl/spi_master_engine_pkg.sv
// Shared types and field layout for the SPI master engine.
// The command word is {cmd, addr, len, wdata}; the header is {cmd, addr}.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SHIFT_H = 3'd2,
    SHIFT_L = 3'd3,
    HOLD    = 3'd4,
    RXPUSH  = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam int CMD_MSB   = 31;
  localparam int CMD_LSB   = 28;
  localparam int ADDR_MSB  = 27;
  localparam int ADDR_LSB  = 24;
  localparam int LEN_MSB   = 23;
  localparam int LEN_LSB   = 16;
  localparam int WDATA_MSB = 15;
  localparam int WDATA_LSB = 0;
  localparam int HDR_BITS  = 8;

  // Data-phase bit count limited to what the shift register can carry.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input int max_len);
    logic [7:0] max8;
    max8 = 8'(max_len);
    return (len > max8) ? max8 : len;
  endfunction

endpackage

// File: rtl/spi_master_engine_if.sv
// Command/response stream between the APB register file (master) and the engine (slave).
interface spi_master_engine_if;
  logic [31:0] stream_data_tx_i;
  logic        stream_data_tx_vld_i;
  logic        stream_data_tx_rdy_o;
  logic [31:0] stream_data_rx_o;
  logic        stream_data_rx_vld_o;
  logic        stream_data_rx_rdy_i;

  modport master (
    output stream_data_tx_i, stream_data_tx_vld_i, stream_data_rx_rdy_i,
    input  stream_data_tx_rdy_o, stream_data_rx_o, stream_data_rx_vld_o
  );

  modport slave (
    input  stream_data_tx_i, stream_data_tx_vld_i, stream_data_rx_rdy_i,
    output stream_data_tx_rdy_o, stream_data_rx_o, stream_data_rx_vld_o
  );
endinterface

// File: rtl/spi_master_engine_half_period_cnt.sv
// Half-period timer: every phase lasts load_i cycles; tick_o marks the last cycle.
// Reloads itself on each tick so consecutive phases chain without a gap.
module spi_half_period_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             pclk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] load_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;

  assign tick_o = (cnt_r == {DIV_W{1'b0}});

  // Down-counter: restart or end of phase reloads, otherwise count while enabled.
  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (restart_i || (en_i && tick_o)) begin
      cnt_r <= load_i - ONE;
    end else if (en_i) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master: one chip-select frame per accepted command word,
// 8 header bits plus up to MAX_LEN data bits, read data returned on the rx stream.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int MAX_LEN  = 16,
  parameter int READ_BIT = 3
) (
  input  logic                pclk_i,
  input  logic                rst_n_i,
  input  logic                spi_clk_div_vld_i,
  input  logic [DIV_W-1:0]    spi_clk_div_i,
  spi_master_engine_if.slave  stream,
  output logic                eot_o,
  output logic                busy_o,
  output logic                spi_sclk_o,
  output logic                spi_cs_n_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i
);

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic [23:0]      sh_r;
  logic [15:0]      rx_sh_r;
  logic [4:0]       bit_r;
  logic [4:0]       last_r;
  logic             rd_r;
  logic             tx_rdy_r;
  logic             rx_vld_r;
  logic [31:0]      rx_data_r;
  logic             sclk_r;
  logic             cs_n_r;
  logic             mosi_r;
  logic             eot_r;
  logic             busy_r;
  logic             tick_s;
  logic             accept_s;
  logic             rd_s;
  logic [7:0]       len_c_s;
  logic [4:0]       last_s;
  logic [23:0]      frame_s;

  assign accept_s = stream.stream_data_tx_vld_i && tx_rdy_r;

  // Decode the incoming word; a read sends zeros in the data phase.
  always_comb begin
    rd_s    = stream.stream_data_tx_i[CMD_LSB + READ_BIT];
    len_c_s = clamp_len(stream.stream_data_tx_i[LEN_MSB:LEN_LSB], MAX_LEN);
    last_s  = 5'(8'(HDR_BITS - 1) + len_c_s);
    if (rd_s) begin
      frame_s = {stream.stream_data_tx_i[CMD_MSB:ADDR_LSB], 16'h0000};
    end else begin
      frame_s = {stream.stream_data_tx_i[CMD_MSB:ADDR_LSB],
                 stream.stream_data_tx_i[WDATA_MSB:WDATA_LSB]};
    end
    if (accept_s && spi_clk_div_vld_i) begin
      div_nxt_s = (spi_clk_div_i == {DIV_W{1'b0}}) ? DIV_ONE : spi_clk_div_i;
    end else begin
      div_nxt_s = div_r;
    end
  end

  spi_half_period_cnt #(.DIV_W(DIV_W)) u_hp_cnt (
    .pclk_i    (pclk_i),
    .rst_n_i   (rst_n_i),
    .en_i      (busy_r),
    .restart_i (accept_s),
    .load_i    (div_nxt_s),
    .tick_o    (tick_s)
  );

  // Frame sequencer; every SPI pin and status output is a register here.
  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= IDLE;
      div_r     <= DIV_ONE;
      sh_r      <= 24'h000000;
      rx_sh_r   <= 16'h0000;
      bit_r     <= 5'd0;
      last_r    <= 5'd0;
      rd_r      <= 1'b0;
      tx_rdy_r  <= 1'b1;
      rx_vld_r  <= 1'b0;
      rx_data_r <= 32'h00000000;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      mosi_r    <= 1'b0;
      eot_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      div_r <= div_nxt_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r  <= SETUP;
            tx_rdy_r <= 1'b0;
            busy_r   <= 1'b1;
            cs_n_r   <= 1'b0;
            sclk_r   <= 1'b0;
            mosi_r   <= frame_s[23];
            sh_r     <= {frame_s[22:0], 1'b0};
            rd_r     <= rd_s;
            last_r   <= last_s;
            bit_r    <= 5'd0;
            rx_sh_r  <= 16'h0000;
          end
        end
        SETUP: begin
          if (tick_s) begin
            state_r <= SHIFT_H;
            sclk_r  <= 1'b1;
          end
        end
        SHIFT_H: begin
          if (tick_s) begin
            sclk_r <= 1'b0;
            if (rd_r && (bit_r >= 5'(HDR_BITS))) begin
              rx_sh_r <= {rx_sh_r[14:0], spi_miso_i};
            end
            if (bit_r == last_r) begin
              state_r <= HOLD;
            end else begin
              state_r <= SHIFT_L;
              mosi_r  <= sh_r[23];
              sh_r    <= {sh_r[22:0], 1'b0};
              bit_r   <= bit_r + 5'd1;
            end
          end
        end
        SHIFT_L: begin
          if (tick_s) begin
            state_r <= SHIFT_H;
            sclk_r  <= 1'b1;
          end
        end
        HOLD: begin
          if (tick_s) begin
            cs_n_r <= 1'b1;
            mosi_r <= 1'b0;
            if (rd_r) begin
              state_r   <= RXPUSH;
              rx_vld_r  <= 1'b1;
              rx_data_r <= {16'h0000, rx_sh_r};
            end else begin
              state_r <= DONE;
              eot_r   <= 1'b1;
            end
          end
        end
        RXPUSH: begin
          if (stream.stream_data_rx_rdy_i) begin
            rx_vld_r <= 1'b0;
            state_r  <= DONE;
            eot_r    <= 1'b1;
          end
        end
        DONE: begin
          eot_r    <= 1'b0;
          busy_r   <= 1'b0;
          tx_rdy_r <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          eot_r    <= 1'b0;
          busy_r   <= 1'b0;
          tx_rdy_r <= 1'b1;
          rx_vld_r <= 1'b0;
          sclk_r   <= 1'b0;
          cs_n_r   <= 1'b1;
          mosi_r   <= 1'b0;
        end
      endcase
    end
  end

  assign stream.stream_data_tx_rdy_o = tx_rdy_r;
  assign stream.stream_data_rx_o     = rx_data_r;
  assign stream.stream_data_rx_vld_o = rx_vld_r;
  assign eot_o      = eot_r;
  assign busy_o     = busy_r;
  assign spi_sclk_o = sclk_r;
  assign spi_cs_n_o = cs_n_r;
  assign spi_mosi_o = mosi_r;

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: table of command words with hand-derived frames,
// a pin monitor that checks each frame against a queue, plus reset and back-to-back cases.
module tb_spi_master_engine;

  typedef struct {
    logic        rd;
    logic [31:0] word;
    logic [15:0] div;
    logic        dvld;
    logic [15:0] reply;
    int          rlen;
    int          nbits;
    logic [23:0] mosi;
    int          cs_low;
    int          period;
    logic [31:0] rx;
  } vec_t;

  typedef struct {
    int          nbits;
    logic [23:0] mosi;
    int          cs_low;
    int          period;
  } frm_t;

  logic        pclk;
  logic        rst_n;
  logic        div_vld;
  logic [15:0] div;
  logic        eot, busy, sclk, cs_n, mosi, miso;

  spi_master_engine_if sif ();

  spi_master_engine #(.DIV_W(16), .MAX_LEN(16), .READ_BIT(3)) dut (
    .pclk_i            (pclk),
    .rst_n_i           (rst_n),
    .spi_clk_div_vld_i (div_vld),
    .spi_clk_div_i     (div),
    .stream            (sif),
    .eot_o             (eot),
    .busy_o            (busy),
    .spi_sclk_o        (sclk),
    .spi_cs_n_o        (cs_n),
    .spi_mosi_o        (mosi),
    .spi_miso_i        (miso)
  );

  int n_chk = 0;
  int n_fail = 0;

  frm_t        frame_q[$];
  logic [31:0] rx_q[$];
  vec_t        vecs[9];

  // Monitor state
  int          cyc = 0, cs_cnt = 0, nrise = 0, idx = 0, last_rise = -1, pmin = 0, pmax = 0;
  int          eot_cnt = 0, rxv_cnt = 0, rdy_bad = 0, frames_done = 0;
  logic [23:0] cap = 24'h0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, abort = 1'b0;
  logic [15:0] reply = 16'h0;
  int          rlen = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Pin monitor, MISO model and per-frame scoreboard compare.
  always @(negedge pclk) begin
    frm_t e;
    int   p;
    cyc++;
    if (busy && sif.stream_data_tx_rdy_o) rdy_bad++;
    if (sif.stream_data_rx_vld_o) rxv_cnt++;
    if (eot) eot_cnt++;
    if (!cs_n && prev_cs) begin
      cs_cnt = 0; cap = 24'h0; nrise = 0; pmin = 1000000; pmax = 0; last_rise = -1; idx = 0;
    end
    if (!cs_n) cs_cnt++;
    if (sclk && !prev_sclk) begin
      cap = {cap[22:0], mosi};
      nrise++;
      if (last_rise >= 0) begin
        p = cyc - last_rise;
        if (p < pmin) pmin = p;
        if (p > pmax) pmax = p;
      end
      last_rise = cyc;
    end
    if (!sclk && prev_sclk) idx++;
    if (idx >= 8 && (idx - 8) < rlen) miso = reply[rlen - 1 - (idx - 8)];
    else miso = 1'b1;
    if (cs_n && !prev_cs) begin
      if (abort) begin
        abort = 1'b0;
      end else if (frame_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_frame: got a frame, expected none");
      end else begin
        e = frame_q.pop_front();
        chk("mosi_bits", 32'(cap), 32'(e.mosi));
        chk("sclk_rises", nrise, e.nbits);
        chk("cs_low_cycles", cs_cnt, e.cs_low);
        chk("sclk_period_max", pmax, e.period);
        chk("sclk_period_min", pmin, e.period);
        frames_done++;
      end
    end
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  task automatic rx_handshake();
    int t, held;
    logic [31:0] d0, ex;
    t = 0;
    while (!sif.stream_data_rx_vld_o && t < 5000) begin @(negedge pclk); t++; end
    if (!sif.stream_data_rx_vld_o) begin
      n_chk++; n_fail++;
      $display("FAIL rx_vld_timeout: got 0, expected 1");
      return;
    end
    held = 0;
    d0 = sif.stream_data_rx_o;
    for (int k = 0; k < 5; k++) begin
      if (sif.stream_data_rx_vld_o && sif.stream_data_rx_o == d0) held++;
      if (k < 4) @(negedge pclk);
    end
    chk("rx_vld_hold", held, 5);
    sif.stream_data_rx_rdy_i = 1'b1;
    @(posedge pclk); #1;
    sif.stream_data_rx_rdy_i = 1'b0;
    if (rx_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_rx: got %0h, expected nothing", d0);
    end else begin
      ex = rx_q.pop_front();
      chk("rx_data", d0, ex);
    end
    @(negedge pclk);
    chk("eot_after_handshake", eot, 1);
  endtask

  task automatic send(input vec_t v, input bit hold);
    int   t, e0, r0;
    frm_t f;
    @(negedge pclk);
    sif.stream_data_tx_i = v.word;
    div = v.div; div_vld = v.dvld; reply = v.reply; rlen = v.rlen;
    sif.stream_data_tx_vld_i = 1'b1;
    t = 0;
    while (!sif.stream_data_tx_rdy_o && t < 2000) begin @(negedge pclk); t++; end
    if (!sif.stream_data_tx_rdy_o) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: tx_rdy got 0, expected 1");
      sif.stream_data_tx_vld_i = 1'b0;
      return;
    end
    f.nbits = v.nbits; f.mosi = v.mosi; f.cs_low = v.cs_low; f.period = v.period;
    frame_q.push_back(f);
    if (v.rd) rx_q.push_back(v.rx);
    e0 = eot_cnt; r0 = rxv_cnt;
    @(posedge pclk); #1;
    if (!hold) sif.stream_data_tx_vld_i = 1'b0;
    div = 16'd5; div_vld = 1'b1;
    chk("busy_after_accept", busy, 1);
    chk("rdy_after_accept", sif.stream_data_tx_rdy_o, 0);
    if (v.rd) rx_handshake();
    if (hold) begin
      t = 0;
      while (!eot && t < 5000) begin @(negedge pclk); t++; end
      chk("eot_seen_with_vld_held", eot, 1);
      chk("rdy_during_eot", sif.stream_data_tx_rdy_o, 0);
      @(posedge pclk); #1;
      sif.stream_data_tx_vld_i = 1'b0;
    end
    t = 0;
    while (busy && t < 5000) begin @(negedge pclk); t++; end
    chk("idle_after_frame", busy, 0);
    chk("eot_pulses", eot_cnt - e0, 1);
    if (!v.rd) chk("rx_vld_on_write", rxv_cnt - r0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, f0;
    vec_t b;
    //          rd    word                             div     dvld  reply     rlen nbits mosi        cs  per rx
    vecs[0] = '{1'b0, {4'h2, 4'h5, 8'd8,  16'hA500}, 16'd1, 1'b1, 16'h0000, 0,  16, 24'h0025A5, 33, 2, 32'h0};
    vecs[1] = '{1'b1, {4'h8, 4'h3, 8'd12, 16'h0000}, 16'd2, 1'b1, 16'h0ABC, 12, 20, 24'h083000, 82, 4, 32'h00000ABC};
    vecs[2] = '{1'b0, {4'h1, 4'hF, 8'd0,  16'hFFFF}, 16'd1, 1'b1, 16'h0000, 0,  8,  24'h00001F, 17, 2, 32'h0};
    vecs[3] = '{1'b0, {4'h7, 4'h0, 8'd20, 16'hC3A5}, 16'd1, 1'b1, 16'h0000, 0,  24, 24'h70C3A5, 49, 2, 32'h0};
    vecs[4] = '{1'b0, {4'h4, 4'h2, 8'd4,  16'hF000}, 16'd0, 1'b1, 16'h0000, 0,  12, 24'h00042F, 25, 2, 32'h0};
    vecs[5] = '{1'b0, {4'h1, 4'h1, 8'd2,  16'h8000}, 16'd3, 1'b1, 16'h0000, 0,  10, 24'h000046, 63, 6, 32'h0};
    vecs[6] = '{1'b0, {4'h2, 4'h2, 8'd0,  16'h0000}, 16'd7, 1'b0, 16'h0000, 0,  8,  24'h000022, 51, 6, 32'h0};
    vecs[7] = '{1'b1, {4'hF, 4'hA, 8'd0,  16'h1234}, 16'd1, 1'b1, 16'h0000, 0,  8,  24'h0000FA, 17, 2, 32'h0};
    vecs[8] = '{1'b1, {4'h8, 4'h0, 8'd16, 16'hFFFF}, 16'd1, 1'b1, 16'h1234, 16, 24, 24'h800000, 49, 2, 32'h00001234};

    rst_n = 1'b0; div = 16'd0; div_vld = 1'b0; miso = 1'b0;
    sif.stream_data_tx_i = 32'h0; sif.stream_data_tx_vld_i = 1'b0; sif.stream_data_rx_rdy_i = 1'b0;
    repeat (3) @(negedge pclk);
    chk("reset_sclk", sclk, 0);
    chk("reset_cs_n", cs_n, 1);
    chk("reset_mosi", mosi, 0);
    chk("reset_rx_vld", sif.stream_data_rx_vld_o, 0);
    chk("reset_rx_data", sif.stream_data_rx_o, 32'h0);
    chk("reset_eot", eot, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tx_rdy", sif.stream_data_tx_rdy_o, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) send(vecs[i], 1'b0);

    // Word held valid through eot must run exactly one frame.
    b = '{1'b0, {4'h3, 4'hC, 8'd0, 16'h0000}, 16'd1, 1'b1, 16'h0, 0, 8, 24'h00003C, 17, 2, 32'h0};
    f0 = frames_done;
    send(b, 1'b1);
    repeat (2) @(posedge pclk);
    chk("single_frame_for_held_vld", frames_done - f0, 1);
    b = '{1'b0, {4'h5, 4'h6, 8'd0, 16'h0000}, 16'd1, 1'b1, 16'h0, 0, 8, 24'h000056, 17, 2, 32'h0};
    send(b, 1'b0);
    chk("second_frame_done", frames_done - f0, 2);

    // Asynchronous reset in the middle of a high SCLK phase.
    @(negedge pclk);
    sif.stream_data_tx_i = {4'h1, 4'h0, 8'd16, 16'hFFFF};
    div = 16'd2; div_vld = 1'b1; sif.stream_data_tx_vld_i = 1'b1;
    t = 0;
    while (!sif.stream_data_tx_rdy_o && t < 100) begin @(negedge pclk); t++; end
    @(posedge pclk); #1;
    sif.stream_data_tx_vld_i = 1'b0;
    abort = 1'b1;
    t = 0;
    while (!sclk && t < 100) begin @(negedge pclk); t++; end
    chk("sclk_high_before_reset", sclk, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_sclk", sclk, 0);
    chk("midframe_reset_cs_n", cs_n, 1);
    chk("midframe_reset_busy", busy, 0);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("tx_rdy_after_reset", sif.stream_data_tx_rdy_o, 1);
    send(vecs[0], 1'b0);

    repeat (4) @(negedge pclk);
    chk("tx_rdy_low_while_busy", rdy_bad, 0);
    chk("frame_queue_drained", frame_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
